// File: rtl/seq_comparator.sv
// Sequential comparator with a single registered output stage, running max/min accumulator
// and a saturating true-compare counter. Define SEQ_COMPARATOR_SIGNED_EN for two's-complement ordering.
module seq_comparator #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           OP,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 CLEAR,
  output logic [WIDTH-1:0]     F,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] MATCH_COUNT
);

  typedef enum logic [2:0] {
    OP_EQ   = 3'd0,
    OP_GT   = 3'd1,
    OP_LT   = 3'd2,
    OP_MAX  = 3'd3,
    OP_MIN  = 3'd4,
    OP_RMAX = 3'd5,
    OP_RMIN = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic a_gt_b(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SEQ_COMPARATOR_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] max_of(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return a_gt_b(b, a) ? b : a;
  endfunction

  function automatic logic [WIDTH-1:0] min_of(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return a_gt_b(a, b) ? b : a;
  endfunction

  logic [WIDTH-1:0]     f_q, f_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 acc_vld_q, acc_vld_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 accept;
  logic                 is_cmp;
  logic                 run_upd;
  logic                 cmp_bit;
  logic [WIDTH-1:0]     result;
  logic [WIDTH-1:0]     acc_base;
  logic [WIDTH-1:0]     acc_next;
  logic [CNT_WIDTH-1:0] cnt_base;

  // Ready depends only on the output register and downstream, never on IN_VALID.
  assign IN_READY = ~out_valid_q | OUT_READY;
  assign accept   = IN_VALID & IN_READY;

  always_comb begin
    is_cmp   = 1'b0;
    run_upd  = 1'b0;
    cmp_bit  = 1'b0;
    result   = '0;
    // A coincident CLEAR makes this sample the first one of a fresh run.
    acc_base = (acc_vld_q & ~CLEAR) ? acc_q : A;
    acc_next = acc_base;

    case (op_e'(OP))
      OP_EQ: begin
        is_cmp  = 1'b1;
        cmp_bit = (A == B);
      end
      OP_GT: begin
        is_cmp  = 1'b1;
        cmp_bit = a_gt_b(A, B);
      end
      OP_LT: begin
        is_cmp  = 1'b1;
        cmp_bit = a_gt_b(B, A);
      end
      OP_MAX:  result = max_of(A, B);
      OP_MIN:  result = min_of(A, B);
      OP_RMAX: begin
        run_upd  = 1'b1;
        acc_next = max_of(acc_base, A);
        result   = acc_next;
      end
      OP_RMIN: begin
        run_upd  = 1'b1;
        acc_next = min_of(acc_base, A);
        result   = acc_next;
      end
      default: result = '0;
    endcase

    if (is_cmp) begin
      result = {{(WIDTH-1){1'b0}}, cmp_bit};
    end
  end

  always_comb begin
    f_d         = f_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      f_d         = result;
      out_valid_d = 1'b1;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end

    acc_d     = acc_q;
    acc_vld_d = acc_vld_q;
    if (CLEAR) begin
      acc_d     = '0;
      acc_vld_d = 1'b0;
    end
    if (accept && run_upd) begin
      acc_d     = acc_next;
      acc_vld_d = 1'b1;
    end

    cnt_base = CLEAR ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (accept && is_cmp && cmp_bit && (cnt_base != '1)) begin
      cnt_d = cnt_base + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      f_q         <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      acc_vld_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      f_q         <= f_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      acc_vld_q   <= acc_vld_d;
      cnt_q       <= cnt_d;
    end
  end

  assign F           = f_q;
  assign OUT_VALID   = out_valid_q;
  assign MATCH_COUNT = cnt_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=4, CNT_WIDTH=8); expectations follow the
// SEQ_COMPARATOR_SIGNED_EN build setting.
`timescale 1ns/1ps
module tb_seq_comparator;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [2:0] OP = '0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic       CLEAR = 1'b0;
  logic [3:0] F;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b1;
  logic [7:0] MATCH_COUNT;

  int n_checks = 0;
  int n_fails  = 0;

  seq_comparator #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .OP(OP),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .CLEAR(CLEAR),
    .F(F), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .MATCH_COUNT(MATCH_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic txn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    OP = op; A = a; B = b; IN_VALID = 1'b1; OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  initial begin
    // Reset with a handshake asserted: must be discarded.
    IN_VALID = 1'b1; OP = 3'd0; A = 4'h5; B = 4'h5;
    #1;
    chk("rst_in_ready", IN_READY, 1);
    tick();
    tick();
    chk("rst_f", F, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_count", MATCH_COUNT, 0);
    chk("rst_in_ready2", IN_READY, 1);
    IN_VALID = 1'b0;
    RST_N = 1'b1;
    tick();
    chk("post_rst_out_valid", OUT_VALID, 0);

    // MAX / MIN
    txn(3'd3, 4'h9, 4'h6);
`ifdef SEQ_COMPARATOR_SIGNED_EN
    chk("max_96", F, 4'h6);
`else
    chk("max_96", F, 4'h9);
`endif
    chk("max_96_vld", OUT_VALID, 1);
    txn(3'd4, 4'h9, 4'h6);
`ifdef SEQ_COMPARATOR_SIGNED_EN
    chk("min_96", F, 4'h9);
`else
    chk("min_96", F, 4'h6);
`endif
    txn(3'd3, 4'h5, 4'h5);
    chk("max_eq", F, 4'h5);
    txn(3'd4, 4'h2, 4'h4);
    chk("min_24", F, 4'h2);

    // Compares and counter
    txn(3'd0, 4'h5, 4'h5);
    chk("eq_55", F, 4'h1);
    chk("cnt_1", MATCH_COUNT, 1);
    txn(3'd0, 4'h5, 4'h4);
    chk("eq_54", F, 4'h0);
    chk("cnt_still_1", MATCH_COUNT, 1);
    txn(3'd1, 4'h3, 4'h2);
    chk("gt_32", F, 4'h1);
    txn(3'd2, 4'h3, 4'h2);
    chk("lt_32", F, 4'h0);
    txn(3'd2, 4'h2, 4'h3);
    chk("lt_23", F, 4'h1);
    chk("cnt_3", MATCH_COUNT, 3);
    txn(3'd1, 4'hF, 4'h1);
`ifdef SEQ_COMPARATOR_SIGNED_EN
    chk("gt_f1", F, 4'h0);
    chk("cnt_gt_f1", MATCH_COUNT, 3);
`else
    chk("gt_f1", F, 4'h1);
    chk("cnt_gt_f1", MATCH_COUNT, 4);
`endif
    txn(3'd7, 4'hF, 4'hF);
    chk("reserved", F, 4'h0);

    // CLEAR alone: counter zeroed, output register untouched
    txn(3'd3, 4'h7, 4'h1);
    OUT_READY = 1'b0; CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    chk("clr_cnt", MATCH_COUNT, 0);
    chk("clr_f", F, 4'h7);
    chk("clr_vld", OUT_VALID, 1);

    // Running max, CLEAR coincident with fifth sample, then mode switching
    txn(3'd5, 4'h3, 4'h0); chk("rmax_1", F, 4'h3);
    txn(3'd5, 4'h7, 4'h0); chk("rmax_2", F, 4'h7);
    txn(3'd5, 4'h2, 4'h0); chk("rmax_3", F, 4'h7);
    txn(3'd5, 4'h7, 4'h0); chk("rmax_4", F, 4'h7);
    CLEAR = 1'b1;
    txn(3'd5, 4'h1, 4'h0);
    CLEAR = 1'b0;
    chk("rmax_clr", F, 4'h1);
    txn(3'd6, 4'h4, 4'h0); chk("rmin_cont", F, 4'h1);
    txn(3'd5, 4'h6, 4'h0); chk("rmax_cont", F, 4'h6);
    txn(3'd6, 4'h5, 4'h0); chk("rmin_5", F, 4'h5);

    // Saturation over 300 back-to-back true compares
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    chk("sat_clr", MATCH_COUNT, 0);
    for (int i = 0; i < 300; i++) begin
      txn(3'd0, 4'h5, 4'h5);
      if (i == 0)   chk("sat_first", MATCH_COUNT, 8'h01);
      if (i == 253) chk("sat_254", MATCH_COUNT, 8'hFE);
      if (i == 254) chk("sat_255", MATCH_COUNT, 8'hFF);
    end
    chk("sat_300", MATCH_COUNT, 8'hFF);
    CLEAR = 1'b1;
    txn(3'd0, 4'h5, 4'h5);
    CLEAR = 1'b0;
    chk("clr_with_true", MATCH_COUNT, 8'h01);

    // Backpressure: output held, ready low for 5 cycles
    txn(3'd3, 4'h3, 4'h2);
    OP = 3'd3; A = 4'h4; B = 4'h1; IN_VALID = 1'b1; OUT_READY = 1'b0;
    #1;
    chk("bp_ready_low", IN_READY, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", IN_READY, 0);
      chk("bp_f", F, 4'h3);
      chk("bp_vld", OUT_VALID, 1);
    end
    OUT_READY = 1'b1;
    #1;
    chk("bp_ready_back", IN_READY, 1);
    tick();
    chk("b2b_1", F, 4'h4);
    A = 4'h2; B = 4'h7;
    tick();
    chk("b2b_2", F, 4'h7);
    chk("b2b_vld", OUT_VALID, 1);
    IN_VALID = 1'b0;
    tick();
    chk("drain_vld", OUT_VALID, 0);
    chk("drain_f", F, 4'h7);

    // Asynchronous reset mid-stream with a pending result
    txn(3'd5, 4'h3, 4'h0);
    OUT_READY = 1'b0;
    #3;
    chk("pre_rst_vld", OUT_VALID, 1);
    RST_N = 1'b0;
    #1;
    chk("arst_f", F, 0);
    chk("arst_vld", OUT_VALID, 0);
    chk("arst_cnt", MATCH_COUNT, 0);
    chk("arst_in_ready", IN_READY, 1);
    #2;
    RST_N = 1'b1;
    tick();
    txn(3'd6, 4'h8, 4'h0);
    chk("post_rst_rmin", F, 4'h8);
    txn(3'd6, 4'h3, 4'h0);
`ifdef SEQ_COMPARATOR_SIGNED_EN
    chk("post_rst_rmin2", F, 4'h8);
`else
    chk("post_rst_rmin2", F, 4'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
